// File: rtl/mem_responder_if.sv
// Request/response bus between the core's control unit (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES wait cycles, byte/half/word access.
// Optional MEM_ACCESS_CNT_EN adds saturating rd_count/wr_count outputs for error-free accesses.
//
// state    | meaning
// S_IDLE   | ready, request captured on req_valid
// S_WAIT   | counting down wait states
// S_ACCESS | array read / read-modify-write, result registered
// S_RESP   | one-cycle rsp_valid pulse
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic                  cap_write;
    logic [ADDR_WIDTH+1:0] cap_addr;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic [31:0]           cap_wdata;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] word_rd;
    logic [31:0] store_word;
    logic [31:0] load_val;
    logic [31:0] lane_shift;
    logic        access_err;

    assign idx     = cap_addr[ADDR_WIDTH+1:2];
    assign word_rd = mem[idx];

    always_comb begin
        access_err = 1'b0;
        case (cap_size)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = cap_addr[0];
            2'b10:   access_err = (cap_addr[1:0] != 2'b00);
            default: access_err = 1'b1;
        endcase
    end

    // Little-endian lane extraction: shift the addressed lane down to bit 0.
    always_comb begin
        lane_shift = word_rd >> {cap_addr[1:0], 3'b000};
        load_val   = 32'd0;
        case (cap_size)
            2'b00:   load_val = cap_unsigned ? {24'd0, lane_shift[7:0]}
                                             : {{24{lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_val = cap_unsigned ? {16'd0, lane_shift[15:0]}
                                             : {{16{lane_shift[15]}}, lane_shift[15:0]};
            2'b10:   load_val = word_rd;
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        store_word = word_rd;
        case (cap_size)
            2'b00:   store_word[{cap_addr[1:0], 3'b000} +: 8]  = cap_wdata[7:0];
            2'b01:   store_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            2'b10:   store_word = cap_wdata;
            default: store_word = word_rd;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ACCESS;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_ACCESS;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            wait_cnt      <= 4'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            cap_write     <= 1'b0;
            cap_addr      <= '0;
            cap_size      <= 2'b00;
            cap_unsigned  <= 1'b0;
            cap_wdata     <= 32'd0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            bus.req_ready <= (state_nxt == S_IDLE);
            bus.rsp_valid <= (state_nxt == S_RESP);
            if (state == S_IDLE && bus.req_valid) begin
                cap_write    <= bus.req_write;
                cap_addr     <= bus.req_addr[ADDR_WIDTH+1:0];
                cap_size     <= bus.req_size;
                cap_unsigned <= bus.req_unsigned;
                cap_wdata    <= bus.req_wdata;
            end
            if (state == S_ACCESS) begin
                bus.rsp_err   <= access_err;
                bus.rsp_rdata <= (access_err || cap_write) ? 32'd0 : load_val;
            end
        end
    end

    // Array has no reset; reset forces S_IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && cap_write && !access_err) begin
            mem[idx] <= store_word;
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (state == S_ACCESS && !access_err) begin
            if (cap_write && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (!cap_write && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: edge-indexed behavioural model plus directed literal checks.
module tb_mem_responder;
    localparam int AW    = 4;
    localparam int W     = 2;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_responder_if bus ();

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return a[0];
        if (sz == 2'd2) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (sz == 2'd0) begin
            sh = 8 * a[1:0];
            mask = 32'hFF << sh;
            return (word & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = 16 * a[1];
            mask = 32'hFFFF << sh;
            return (word & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    // Model: request accepted at edge E is performed at edge E+W+1, next acceptance at E+W+3.
    logic [31:0] mdl_mem [DEPTH];
    int          cyc       = 0;
    int          acc_edge  = -1;
    int          free_edge = 0;
    bit          pend      = 1'b0;
    bit          m_write;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    bit          m_uns;
    logic [31:0] m_wdata;
    logic        exp_valid = 1'b0;
    logic        exp_ready = 1'b1;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err   = 1'b0;
    int          exp_rd    = 0;
    int          exp_wr    = 0;
    bit          chk_en    = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      = 1'b0;
            free_edge = 0;
            exp_valid = 1'b0;
            exp_ready = 1'b1;
            exp_rdata = 32'd0;
            exp_err   = 1'b0;
            exp_rd    = 0;
            exp_wr    = 0;
        end else begin
            exp_valid = 1'b0;
            if (pend && cyc == acc_edge) begin
                int i;
                i = int'(m_addr[AW+1:2]);
                pend      = 1'b0;
                exp_valid = 1'b1;
                exp_err   = model_err(m_addr, m_size);
                exp_rdata = 32'd0;
                if (!exp_err) begin
                    if (m_write) begin
                        mdl_mem[i] = model_store(mdl_mem[i], m_addr, m_size, m_wdata);
                        if (exp_wr < 16'hFFFF) exp_wr++;
                    end else begin
                        exp_rdata = model_load(mdl_mem[i], m_addr, m_size, m_uns);
                        if (exp_rd < 16'hFFFF) exp_rd++;
                    end
                end
            end
            if (cyc >= free_edge && bus.req_valid) begin
                m_write   = bus.req_write;
                m_addr    = bus.req_addr;
                m_size    = bus.req_size;
                m_uns     = bus.req_unsigned;
                m_wdata   = bus.req_wdata;
                pend      = 1'b1;
                acc_edge  = cyc + W + 1;
                free_edge = cyc + W + 3;
            end
            exp_ready = (cyc + 1 >= free_edge);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("rsp_err",   32'(bus.rsp_err), 32'(exp_err));
`ifdef MEM_ACCESS_CNT_EN
            check("rd_count", 32'(rd_count), 32'(exp_rd));
            check("wr_count", 32'(wr_count), 32'(exp_wr));
`endif
        end
    end

    // Issues one request, returns the response and the cycle (1-based) after acceptance where rsp_valid was seen.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
        bit acc = 1'b0;
        bit got = 1'b0;
        logic r;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            r = bus.req_ready;
            @(posedge clk);
            if (r) acc = 1'b1;
        end
        #1 bus.req_valid = 1'b0;
        lat = 0;
        rd  = 32'hX;
        err = 1'bX;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1'b1;
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'd0;

        #12;
        check("reset_ready", 32'(bus.req_ready), 32'd1);
        check("reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rdata", bus.rsp_rdata, 32'd0);
        check("reset_err",   32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, rd, err, lat);
        end

        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, err, lat);
        check("sw_lat", 32'(lat), 32'd4);
        check("sw_err", 32'(err), 32'd0);
        check("sw_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, err, lat);
        check("lw_lat", 32'(lat), 32'd4);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(err), 32'd0);

        do_req(1'b1, 32'h11, 2'd0, 1'b0, 32'h80, rd, err, lat);
        do_req(1'b0, 32'h11, 2'd0, 1'b0, 32'd0, rd, err, lat);
        check("lb_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h11, 2'd0, 1'b1, 32'd0, rd, err, lat);
        check("lbu", rd, 32'h00000080);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, err, lat);
        check("lw_after_sb", rd, 32'hDEAD80EF);
        do_req(1'b0, 32'h12, 2'd1, 1'b0, 32'd0, rd, err, lat);
        check("lh_signed", rd, 32'hFFFFDEAD);

        do_req(1'b0, 32'h13, 2'd1, 1'b0, 32'd0, rd, err, lat);
        check("lh_mis_err", 32'(err), 32'd1);
        check("lh_mis_rdata", rd, 32'd0);
        do_req(1'b1, 32'h12, 2'd2, 1'b0, 32'h11223344, rd, err, lat);
        check("sw_mis_err", 32'(err), 32'd1);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, err, lat);
        check("lw_after_mis", rd, 32'hDEAD80EF);
        do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0, rd, err, lat);
        check("size11_err", 32'(err), 32'd1);
        do_req(1'b0, 32'h10 + 32'(4 * DEPTH), 2'd2, 1'b0, 32'd0, rd, err, lat);
        check("alias_rdata", rd, 32'hDEAD80EF);

        // Store aborted by reset during WAIT must leave the word untouched.
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_size  = 2'd2;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mid_err",   32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (6) @(posedge clk);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, err, lat);
        check("rst_store_discarded", rd, 32'hDEAD80EF);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (i == 200) reset = 1'b0;
            if (i == 201) reset = 1'b1;
            bus.req_valid    = ($urandom_range(0, 3) != 0);
            bus.req_write    = $urandom_range(0, 1) != 0;
            bus.req_addr     = $urandom_range(0, 255);
            bus.req_size     = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.req_unsigned = $urandom_range(0, 1) != 0;
            bus.req_wdata    = $urandom;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
